// File: rtl/dtc_vote_window.sv
// Windowed majority vote over classifier decisions: counts per-class votes for
// up to WIN samples, scans for the argmax (lowest index wins ties), emits it.
module dtc_vote_ctr #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module dtc_vote_window #(
  parameter int CLASS_W = 3,
  parameter int WIN     = 16,
  parameter int CNT_W   = $clog2(WIN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] in_class,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic [CNT_W-1:0]   out_count,
  output logic [CNT_W-1:0]   out_total
);
  localparam int NCLS = 1 << CLASS_W;

  typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_samples;
  logic [CLASS_W-1:0] r_idx;
  logic [CLASS_W-1:0] r_best_cls;
  logic [CNT_W-1:0]   r_best_cnt;
  logic               r_out_valid;
  logic [CLASS_W-1:0] r_out_class;
  logic [CNT_W-1:0]   r_out_count;
  logic [CNT_W-1:0]   r_out_total;

  logic [NCLS-1:0][CNT_W-1:0] w_votes;
  logic                       w_acc;
  logic [CNT_W-1:0]           w_samples_n;
  logic                       w_close;
  logic                       w_clr;
  logic                       w_upd;

  assign in_ready    = (r_state == ACCUM) && !rst;
  assign w_acc       = in_valid && in_ready;
  assign w_samples_n = r_samples + CNT_W'(w_acc);
  // Flush on an empty window is dropped; a flush coinciding with the filling
  // sample closes the window once.
  assign w_close     = (r_state == ACCUM) &&
                       ((w_acc && (w_samples_n == CNT_W'(WIN))) ||
                        (flush && (w_samples_n != '0)));
  assign w_clr       = (r_state == OUT) && out_ready;
  assign w_upd       = w_votes[r_idx] > r_best_cnt;

  for (genvar g = 0; g < NCLS; g++) begin : g_vote
    dtc_vote_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_inc (w_acc && (in_class == CLASS_W'(g))),
      .o_cnt (w_votes[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_samples   <= '0;
      r_idx       <= '0;
      r_best_cls  <= '0;
      r_best_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_out_count <= '0;
      r_out_total <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          r_samples <= w_samples_n;
          if (w_close) begin
            r_state    <= SCAN;
            r_idx      <= '0;
            r_best_cls <= '0;
            r_best_cnt <= '0;
          end
        end
        SCAN: begin
          if (w_upd) begin
            r_best_cls <= r_idx;
            r_best_cnt <= w_votes[r_idx];
          end
          r_idx <= r_idx + 1'b1;
          if (r_idx == CLASS_W'(NCLS - 1)) begin
            r_out_class <= w_upd ? r_idx : r_best_cls;
            r_out_count <= w_upd ? w_votes[r_idx] : r_best_cnt;
            r_out_total <= r_samples;
            r_out_valid <= 1'b1;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_samples   <= '0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_class = r_out_class;
  assign out_count = r_out_count;
  assign out_total = r_out_total;
endmodule

// File: tb/tb_dtc_vote_window.sv
// Directed window table plus stall, reset-in-scan and randomised windows
// checked against an argmax model with lowest-index tie-break.
module tb_dtc_vote_window;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_class = '0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_class;
  logic [4:0] out_count;
  logic [4:0] out_total;

  int n_vec = 0;
  int n_err = 0;

  dtc_vote_window dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .out_count(out_count),
    .out_total(out_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [2:0] c [16];
    bit         fl;
    int         ec, en, et;
  } win_t;

  win_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Present one sample (optionally with flush); returns #1 after the accepting edge.
  task automatic push(input logic [2:0] c, input bit f);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1; in_class = c; flush = f;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  // Wait for out_valid, counting edges since the last accept; optionally take it.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!out_valid && lat < 300);
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask

  task automatic take;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_res(input string tag, input int ec, input int en, input int et);
    chk({tag, "_class"}, out_class, ec);
    chk({tag, "_count"}, out_count, en);
    chk({tag, "_total"}, out_total, et);
  endtask

  initial begin
    int lat;
    logic [2:0] sc, hc;
    logic [4:0] hn, ht;
    int votes [8];
    int len, bc, bn;
    logic [2:0] rc;

    // ---- table fill ----
    for (int i = 0; i < 6; i++) begin tbl[i].n = 0; tbl[i].fl = 0; end
    tbl[0].n = 16; for (int k = 0; k < 16; k++) tbl[0].c[k] = 3'd5;
    tbl[0].ec = 5; tbl[0].en = 16; tbl[0].et = 16;
    tbl[1].n = 16;
    for (int k = 0; k < 16; k++) begin
      sc = (k < 12) ? ((k % 2) ? 3'd6 : 3'd2) : 3'd0;
      tbl[1].c[k] = sc;
    end
    tbl[1].ec = 2; tbl[1].en = 6; tbl[1].et = 16;
    tbl[2].n = 3; tbl[2].fl = 1;
    tbl[2].c[0] = 3'd1; tbl[2].c[1] = 3'd1; tbl[2].c[2] = 3'd4;
    tbl[2].ec = 1; tbl[2].en = 2; tbl[2].et = 3;
    tbl[3].n = 7; tbl[3].fl = 1;
    for (int k = 0; k < 7; k++) tbl[3].c[k] = (k < 3) ? 3'd3 : 3'd7;
    tbl[3].ec = 7; tbl[3].en = 4; tbl[3].et = 7;
    tbl[4].n = 1; tbl[4].fl = 1; tbl[4].c[0] = 3'd0;
    tbl[4].ec = 0; tbl[4].en = 1; tbl[4].et = 1;
    tbl[5].n = 2; tbl[5].fl = 1; tbl[5].c[0] = 3'd4; tbl[5].c[1] = 3'd0;
    tbl[5].ec = 0; tbl[5].en = 1; tbl[5].et = 2;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    check_res("rst", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // ---- table-driven windows ----
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        push(tbl[i].c[k], tbl[i].fl && (k == tbl[i].n - 1));
      wait_out(lat);
      chk($sformatf("tbl%0d_latency", i), lat, 8);
      check_res($sformatf("tbl%0d", i), tbl[i].ec, tbl[i].en, tbl[i].et);
      take();
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready_after", i), in_ready, 1);
      chk($sformatf("tbl%0d_out_valid_after", i), out_valid, 0);
    end

    // ---- flush on empty window does nothing; separate flush pulse closes ----
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    repeat (15) @(negedge clk);
    chk("empty_flush_out_valid", out_valid, 0);
    chk("empty_flush_in_ready", in_ready, 1);
    push(3'd1, 0); push(3'd1, 0); push(3'd4, 0);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    wait_out(lat);
    chk("sep_flush_latency", lat, 8);
    check_res("sep_flush", 1, 2, 3);
    take();

    // ---- output stall with pending input ----
    for (int k = 0; k < 16; k++) push(3'd3, 0);
    wait_out(lat);
    hc = out_class; hn = out_count; ht = out_total;
    check_res("stall_first", 3, 16, 16);
    in_valid = 1'b1; in_class = 3'd6;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      check_res("stall_hold", hc, hn, ht);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("stall_release_valid", out_valid, 0);
    push(3'd6, 1);
    wait_out(lat);
    check_res("after_stall", 6, 1, 1);
    take();

    // ---- reset during SCAN ----
    for (int k = 0; k < 16; k++) push(3'd2, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("scan_rst_out_valid", out_valid, 0);
    chk("scan_rst_in_ready", in_ready, 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 16; k++) push(3'd7, 0);
    wait_out(lat);
    chk("after_rst_latency", lat, 8);
    check_res("after_rst", 7, 16, 16);
    take();

    // ---- random windows vs argmax model ----
    for (int w = 0; w < 100; w++) begin
      for (int j = 0; j < 8; j++) votes[j] = 0;
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 16;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 1) == 1) @(negedge clk);
        rc = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) rc = 3'd4;
        votes[rc]++;
        push(rc, (k == len - 1) && (len < 16 || $urandom_range(0, 1) == 1));
      end
      bc = 0; bn = 0;
      for (int j = 0; j < 8; j++) if (votes[j] > bn) begin bc = j; bn = votes[j]; end
      wait_out(lat);
      check_res($sformatf("rnd%0d", w), bc, bn, len);
      take();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dtc_vote_window.md
Name: dtc_vote_window

Overview:
- Downstream consumer of the combinational decision-tree classifier. Takes its 3-bit class code per sample over a valid/ready stream.
- Counts per-class votes over a window of WIN samples, or fewer if the window is flushed early.
- Emits the majority class and its vote count on an output valid/ready stream.
- Converts per-sample tree decisions into a windowed, debounced class decision for the system controller.

Parameters:
- CLASS_W, 3, class code width; number of classes NCLS = 2**CLASS_W = 8.
- WIN, 16, samples per window; legal range 1..255.
- CNT_W, $clog2(WIN+1), width of vote and sample counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  class sample valid.
- in_ready  out  1  block can accept a sample.
- in_class  in  CLASS_W  class code from tree output.
- flush  in  1  close current window early; one-cycle pulse.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_class  out  CLASS_W  majority class.
- out_count  out  CNT_W  votes received by out_class.
- out_total  out  CNT_W  samples in the window just closed.

Behaviour:
- Reset (async, any state, including mid-SCAN or OUT):
  - state=ACCUM.
  - All 8 vote counters, sample counter and scan index = 0.
  - out_valid=0, out_class=0, out_count=0, out_total=0.
  - in_ready=0 while rst is high.
- FSM states: ACCUM, SCAN, OUT.
- ACCUM:
  - in_ready=1.
  - On accept (in_valid & in_ready): vote[in_class]++ and samples++.
  - When an accept makes samples==WIN, next state is SCAN.
  - flush with samples>=1 (counting a same-cycle accept): next state is SCAN. The same-cycle sample is counted.
  - flush with samples==0 and no same-cycle accept: ignored, stay in ACCUM.
  - Window-full and flush in the same cycle: treated as a single window close.
- SCAN:
  - in_ready=0; flush ignored.
  - Walks the class index 0..NCLS-1, one per cycle (8 cycles).
  - Tracks best_cls and best_cnt; updates only when vote[i] > best_cnt (strict).
  - Ties therefore resolve to the lowest class index.
  - After index NCLS-1, registers out_class=best_cls, out_count=best_cnt, out_total=samples, then goes to OUT.
- OUT:
  - out_valid=1; in_ready=0.
  - out_* held stable until out_ready is sampled high.
  - On handshake: out_valid=0, all counters cleared, return to ACCUM. in_ready is high the next cycle.
  - out_ready high on the first OUT cycle completes the handshake in that cycle.
- Latency: last accept at cycle t → SCAN occupies t+1..t+8 → out_valid=1 at t+9.
  - Minimum window-to-window turnaround is WIN+9 cycles plus the output stall.
- Width rules:
  - Vote counters cannot overflow: max value WIN fits CNT_W.
  - out_count <= out_total <= WIN always.
- Samples presented while in_ready=0 are not consumed. The source holds them per valid/ready rules.
- No combinational path from in_valid, out_ready or flush to any output.

Test Plan:
- Reset then 16 samples all class 5, out_ready=1 → out_valid 9 cycles after the 16th accept; out_class=5, out_count=16, out_total=16; in_ready back high the next cycle.
- 16 samples: 6×class 2, 6×class 6, 4×class 0 → tie → out_class=2, out_count=6, out_total=16.
- 3 samples (1,1,4) then flush pulse → out_class=1, out_count=2, out_total=3. Flush with an empty window → no output. Flush in the same cycle as the 3rd accept → out_total=3.
- out_ready held low 20 cycles in OUT → out_valid and out_* stable, in_ready=0 and incoming samples not consumed. out_ready=1 → single handshake, next window starts from zero counts.
- Assert rst during SCAN (cycle 4 of 8) → out_valid=0 and in_ready=0 immediately. After release, a fresh 16-sample window of class 7 → out_class=7, out_count=16.
- Random in_valid (50%) with class codes from the tree over 100 windows → out_class/out_count/out_total match a software argmax model with lowest-index tie-break.
